// File: rtl/dispatch_ctrl_pkg.sv
// Shared constants, widths, FSM encoding and lane helpers for the dispatch
// scheduler of the rename/ROB back-end.
package dispatch_ctrl_pkg;

  localparam int N_WAY        = 4;
  localparam int N_ROB        = 32;
  localparam int N_RS         = 8;
  localparam int N_PR         = N_ROB + 32;
  localparam int BR_MAX       = 2;
  localparam int INIT_CYCLES  = 2;
  localparam int FLUSH_CYCLES = 2;

  localparam int ROB_W    = $clog2(N_ROB) + 1;
  localparam int PR_W     = $clog2(N_PR) + 1;
  localparam int RS_W     = $clog2(N_RS) + 1;
  localparam int K_W      = $clog2(N_WAY) + 1;
  localparam int BR_W     = $clog2(BR_MAX) + 1;
  localparam int HOLD_MAX = (INIT_CYCLES > FLUSH_CYCLES) ? INIT_CYCLES : FLUSH_CYCLES;
  localparam int TMR_W    = $clog2(HOLD_MAX) + 1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } DISP_STATE;

  function automatic logic [K_W-1:0] popcount_lanes(input logic [N_WAY-1:0] v);
    logic [K_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_WAY; i++) begin
      cnt = cnt + K_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dispatch_grant.sv
// Combinational grant width: longest valid in-order prefix that fits every
// resource limit and the remaining branch budget.
module dispatch_grant
  import dispatch_ctrl_pkg::*;
(
  input  logic [N_WAY-1:0] inst_valid,
  input  logic [N_WAY-1:0] branch_inst,
  input  logic [ROB_W-1:0] rob_free,
  input  logic [PR_W-1:0]  pr_free,
  input  logic [RS_W-1:0]  rs_free,
  input  logic [BR_W-1:0]  br_budget,
  output logic [K_W-1:0]   k
);

  logic [31:0] need_s;
  logic [31:0] br_cnt_s;
  logic        run_ok_s;

  // Walk lanes oldest-first; the first lane that fails closes the prefix.
  always_comb begin
    k        = '0;
    need_s   = 32'd0;
    br_cnt_s = 32'd0;
    run_ok_s = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      need_s   = 32'(i) + 32'd1;
      br_cnt_s = br_cnt_s + 32'(branch_inst[i]);
      if (run_ok_s && inst_valid[i] &&
          (need_s <= 32'(rob_free)) &&
          (need_s <= 32'(pr_free)) &&
          (need_s <= 32'(rs_free)) &&
          (br_cnt_s <= 32'(br_budget))) begin
        k = K_W'(need_s);
      end else begin
        run_ok_s = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch scheduler: zero-cycle grant over the decode lanes, init/flush hold
// windows and the in-flight branch counter.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [N_WAY-1:0]  inst_valid,
  input  logic [N_WAY-1:0]  branch_inst,
  input  logic [ROB_W-1:0]  rob_free,
  input  logic [PR_W-1:0]   pr_free,
  input  logic [RS_W-1:0]   rs_free,
  input  logic              branch_haz,
  input  logic              branch_resolved,
  output logic [N_WAY-1:0]  dispatch_en,
  output logic [K_W-1:0]    dispatch_num,
  output logic              stall,
  output logic [1:0]        ctrl_state,
  output logic [BR_W-1:0]   br_inflight
);

  DISP_STATE        state_r;
  DISP_STATE        state_nxt_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_nxt_s;
  logic [BR_W-1:0]  br_inflight_r;
  logic [BR_W-1:0]  br_nxt_s;
  logic [BR_W-1:0]  br_budget_s;
  logic [K_W-1:0]   k_grant_s;
  logic [K_W-1:0]   k_s;
  logic [31:0]      br_sum_s;

  // Remaining branch budget; clamps to zero should the counter ever overrun.
  always_comb begin
    br_budget_s = '0;
    if (32'(br_inflight_r) <= 32'(BR_MAX)) begin
      br_budget_s = BR_W'(BR_MAX) - br_inflight_r;
    end else begin
      br_budget_s = '0;
    end
  end

  dispatch_grant u_grant (
    .inst_valid  (inst_valid),
    .branch_inst (branch_inst),
    .rob_free    (rob_free),
    .pr_free     (pr_free),
    .rs_free     (rs_free),
    .br_budget   (br_budget_s),
    .k           (k_grant_s)
  );

  // Grant is only honoured in RUN, outside reset and not on a mispredict cycle.
  always_comb begin
    k_s          = '0;
    dispatch_en  = '0;
    if (reset) begin
      k_s = '0;
    end else if ((state_r == RUN) && !branch_haz) begin
      k_s = k_grant_s;
    end else begin
      k_s = '0;
    end
    for (int i = 0; i < N_WAY; i++) begin
      dispatch_en[i] = (32'(i) < 32'(k_s));
    end
    dispatch_num = k_s;
    stall        = |(inst_valid & ~dispatch_en);
  end

  // Next state and hold timer.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    case (state_r)
      INIT: begin
        if (timer_r == '0) begin
          state_nxt_s = RUN;
        end else begin
          timer_nxt_s = timer_r - TMR_W'(1);
        end
      end
      RUN: begin
        if (branch_haz) begin
          state_nxt_s = FLUSH;
          timer_nxt_s = TMR_W'(FLUSH_CYCLES - 1);
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (branch_haz) begin
          timer_nxt_s = TMR_W'(FLUSH_CYCLES - 1);
        end else if (timer_r == '0) begin
          state_nxt_s = RUN;
        end else begin
          timer_nxt_s = timer_r - TMR_W'(1);
        end
      end
      default: begin
        state_nxt_s = INIT;
        timer_nxt_s = TMR_W'(INIT_CYCLES - 1);
      end
    endcase
  end

  // In-flight branch count: dispatch and resolve both apply, floor at zero.
  always_comb begin
    br_sum_s = 32'(br_inflight_r) + 32'(popcount_lanes(branch_inst & dispatch_en));
    br_nxt_s = '0;
    if (branch_haz) begin
      br_nxt_s = '0;
    end else if (branch_resolved && (br_sum_s != 32'd0)) begin
      br_nxt_s = BR_W'(br_sum_s - 32'd1);
    end else begin
      br_nxt_s = BR_W'(br_sum_s);
    end
  end

  // Control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= INIT;
      timer_r       <= TMR_W'(INIT_CYCLES - 1);
      br_inflight_r <= '0;
    end else begin
      state_r       <= state_nxt_s;
      timer_r       <= timer_nxt_s;
      br_inflight_r <= br_nxt_s;
    end
  end

  assign ctrl_state  = state_r;
  assign br_inflight = br_inflight_r;

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
Dispatch scheduler for the rename/ROB back-end (rob, map_table, free_list, architecture_table). Each cycle it decides how many in-order decode lanes may dispatch. The limits are free ROB entries, free physical registers, free reservation-station slots and an in-flight-branch budget. It also sequences the post-reset init window and the post-mispredict flush window, during which dispatch is blocked. Its dispatch_num output drives the free list; dispatch_en gates the per-lane valid bits into the ROB and map table.

Parameters:
N_WAY, `N_WAY (package, default 4), dispatch width
N_ROB, `N_ROB (default 32), ROB entries
N_RS, 8, reservation-station entries
N_PR, `N_ROB+32, physical registers
BR_MAX, 2, maximum unresolved branches in flight
INIT_CYCLES, 2, cycles dispatch is held after reset while the map table and free list initialise
FLUSH_CYCLES, 2, cycles dispatch is held after branch_haz

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
inst_valid  in  N_WAY  lane holds a decoded instruction; lane 0 is oldest
branch_inst  in  N_WAY  lane holds a branch
rob_free  in  $clog2(N_ROB)+1  free ROB entries this cycle
pr_free  in  $clog2(N_PR)+1  free physical registers this cycle
rs_free  in  $clog2(N_RS)+1  free RS entries this cycle
branch_haz  in  1  mispredict flush, from the ROB
branch_resolved  in  1  one in-flight branch resolved correctly this cycle
dispatch_en  out  N_WAY  per-lane grant, thermometer-coded from lane 0
dispatch_num  out  $clog2(N_WAY)+1  popcount of dispatch_en
stall  out  1  some valid lane was not granted
ctrl_state  out  2  INIT=0, RUN=1, FLUSH=2
br_inflight  out  $clog2(BR_MAX)+1  unresolved dispatched branches

Behaviour:
- Clock and reset: one clock, clock. reset is synchronous and active-high. The state register, the hold timer and br_inflight are registered. dispatch_en, dispatch_num and stall are combinational from the current inputs and registered state (zero-cycle grant).
- Reset: next edge gives ctrl_state=INIT, timer=INIT_CYCLES-1, br_inflight=0. While reset is high, dispatch_en=0, dispatch_num=0, stall=|inst_valid.
- INIT: grant is 0. Timer decrements each cycle. At timer==0 the next state is RUN. branch_haz is ignored in INIT.
- RUN: grant k is the largest value in 0..N_WAY meeting all of:
  - lanes 0..k-1 all have inst_valid=1; nothing is granted past the first invalid lane;
  - k <= rob_free, k <= pr_free, k <= rs_free;
  - popcount(branch_inst[k-1:0]) <= BR_MAX - br_inflight.
- Grant outputs: dispatch_en = (1<<k)-1 and dispatch_num = k.
- RUN with branch_haz=1: k is forced to 0 that cycle. Next state is FLUSH, timer=FLUSH_CYCLES-1.
- FLUSH: grant is 0 and the timer decrements; timer==0 leads to RUN. A branch_haz during FLUSH reloads the timer to FLUSH_CYCLES-1.
- stall: stall = |(inst_valid & ~dispatch_en) in every state.
- br_inflight next value:
  - branch_haz=1 (in any state): 0;
  - otherwise: br_inflight + popcount(branch_inst & dispatch_en) - branch_resolved.
  - Dispatch and resolve in the same cycle are both applied.
  - branch_resolved with br_inflight==0 and no branch dispatched is ignored (saturates at 0).
  - The sum never exceeds BR_MAX, by construction of the grant rule.
- Width rules: resource inputs wider than N_WAY are compared at full width, with no truncation.

Decomposition:
- Package (alongside DISPATCH_PACKET, etc.): typedef enum logic [1:0] DISP_STATE {INIT, RUN, FLUSH}, plus the constants N_RS, BR_MAX, INIT_CYCLES, FLUSH_CYCLES.
- One combinational sub-module, dispatch_grant. Inputs: inst_valid, branch_inst, rob_free, pr_free, rs_free, the branch budget. Output: k.
- The FSM, timer and br_inflight stay in dispatch_ctrl.

Test Plan:
1. Reset, then release with inst_valid=1111, all resources 8, no branches -> dispatch_num=0 and ctrl_state=INIT for 2 cycles; then RUN, dispatch_num=4, dispatch_en=1111, stall=0.
2. RUN, inst_valid=1011, resources plentiful -> dispatch_en=0011, dispatch_num=2, stall=1.
3. RUN, inst_valid=1111, rob_free=3, rs_free=8, pr_free=1 -> dispatch_num=1, dispatch_en=0001, stall=1; then pr_free=0 -> dispatch_num=0.
4. RUN, br_inflight=1, branch_inst=0101, inst_valid=1111 -> dispatch_num=2 (lane 2 would exceed BR_MAX), br_inflight becomes 2. Next cycle: branch_resolved=1, no branch granted -> br_inflight=1.
5. RUN, br_inflight=2, branch_haz=1, inst_valid=1111 -> same cycle dispatch_num=0. Next cycle: FLUSH, br_inflight=0, dispatch_num=0 for 2 cycles, then RUN with dispatch_num=4.
6. In FLUSH, assert reset for one cycle -> next cycle ctrl_state=INIT, br_inflight=0, timer reloaded; RUN is reached 2 cycles after reset deasserts.
